// File: rtl/cpu_run_controller.sv
// Host-side run controller for the CPU control FSM: sequences RUN/STEP/STOP/RESET_CPU commands,
// parks the CPU on instruction boundaries and keeps saturating instruction/cycle counts.
module cpu_run_controller #(
    parameter int COUNT_WIDTH  = 32,
    parameter int STEP_WIDTH   = 16,
    parameter int RESET_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [STEP_WIDTH-1:0]  cmd_steps,
    output logic                   cpu_execute,
    output logic                   cpu_reset,
    input  logic                   cpu_do_next,
    input  logic                   cpu_do_halt,
    output logic                   busy,
    output logic                   halted,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    localparam logic [1:0] OP_RUN   = 2'd0;
    localparam logic [1:0] OP_STEP  = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_RESET = 2'd3;
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {S_CLR, S_IDLE, S_RUN, S_STEP, S_STOPPING, S_HALTED} state_t;

    state_t                  state, state_nxt;
    logic [RC_W-1:0]         rst_cnt, rst_cnt_nxt;
    logic [STEP_WIDTH-1:0]   remaining, remaining_nxt;
    logic                    done_nxt, execute_nxt, cpu_reset_nxt, busy_nxt, ready_nxt, halted_nxt;
    logic [COUNT_WIDTH-1:0]  instr_nxt, cycle_nxt;
    logic                    accept, reset_cmd;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    assign accept    = cmd_valid && cmd_ready;
    assign reset_cmd = accept && (cmd_op == OP_RESET);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_CLR;
            rst_cnt     <= '0;
            cpu_execute <= 1'b0;
            cpu_reset   <= 1'b1;
            busy        <= 1'b1;
            halted      <= 1'b0;
            done        <= 1'b0;
            cmd_ready   <= 1'b0;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            cpu_execute <= execute_nxt;
            cpu_reset   <= cpu_reset_nxt;
            busy        <= busy_nxt;
            halted      <= halted_nxt;
            done        <= done_nxt;
            cmd_ready   <= ready_nxt;
            instr_count <= instr_nxt;
            cycle_count <= cycle_nxt;
        end
    end

    always_ff @(posedge clock) begin
        remaining <= remaining_nxt;
    end

    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        case (state)
            S_CLR: begin
                if (rst_cnt == RC_LAST) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    rst_cnt_nxt = rst_cnt + RC_W'(1);
                end
            end
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_RUN:   state_nxt = S_RUN;
                        OP_STEP: begin
                            if (cmd_steps != '0) begin
                                state_nxt     = S_STEP;
                                remaining_nxt = cmd_steps;
                            end else begin
                                done_nxt = 1'b1;
                            end
                        end
                        OP_STOP:  done_nxt  = 1'b1;
                        default:  state_nxt = S_CLR;
                    endcase
                end
            end
            S_HALTED: begin
                if (reset_cmd) state_nxt = S_CLR;
                else if (accept) done_nxt = 1'b1;
            end
            S_RUN, S_STEP, S_STOPPING: begin
                // RESET_CPU beats halt, which beats step exhaustion, STOP completion and new commands
                if (reset_cmd) begin
                    state_nxt = S_CLR;
                end else if (cpu_do_halt) begin
                    state_nxt = S_HALTED;
                    done_nxt  = 1'b1;
                end else if (state == S_STOPPING) begin
                    if (cpu_do_next) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (state == S_STEP && cpu_do_next && remaining == STEP_WIDTH'(1)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    if (state == S_STEP && cpu_do_next) remaining_nxt = remaining - STEP_WIDTH'(1);
                    if (accept && cmd_op == OP_STOP) state_nxt = S_STOPPING;
                end
            end
            default: state_nxt = S_CLR;
        endcase
        if (state_nxt == S_CLR && state != S_CLR) rst_cnt_nxt = '0;
    end

    // Registered outputs follow the state being entered, so execute drops on the ending edge itself
    always_comb begin
        execute_nxt   = (state_nxt == S_RUN) || (state_nxt == S_STEP) || (state_nxt == S_STOPPING);
        cpu_reset_nxt = (state_nxt == S_CLR);
        busy_nxt      = execute_nxt || (state_nxt == S_CLR);
        ready_nxt     = (state_nxt == S_IDLE) || (state_nxt == S_HALTED) ||
                        (state_nxt == S_RUN)  || (state_nxt == S_STEP);
        halted_nxt    = (state_nxt == S_HALTED);
        instr_nxt     = instr_count;
        cycle_nxt     = cycle_count;
        if (state_nxt == S_CLR) begin
            instr_nxt = '0;
            cycle_nxt = '0;
        end else if (cpu_execute) begin
            cycle_nxt = sat_inc(cycle_count);
            if (cpu_do_next) instr_nxt = sat_inc(instr_count);
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a 5-cycle-per-instruction CPU model drives do_next/do_halt,
// and expected counters at each done pulse are queued when commands are issued.
module tb_cpu_run_controller;

    localparam int INSTR_LEN = 5;
    localparam logic [1:0] OP_RUN = 2'd0, OP_STEP = 2'd1, OP_STOP = 2'd2, OP_RESET = 2'd3;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] cycle;
        logic        halt;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_steps = 16'd0;
    logic        cpu_execute, cpu_reset, cpu_do_next, cpu_do_halt;
    logic        busy, halted, done;
    logic [31:0] instr_count, cycle_count;

    int   n_chk = 0;
    int   n_err = 0;
    rec_t exp_q[$];
    rec_t got, expv;

    int phase = 0;
    int retired = 0;
    int halt_after = -1;

    cpu_run_controller dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cpu_execute(cpu_execute), .cpu_reset(cpu_reset),
        .cpu_do_next(cpu_do_next), .cpu_do_halt(cpu_do_halt), .busy(busy), .halted(halted),
        .done(done), .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // CPU model: retires one instruction every INSTR_LEN executing cycles, phase 0 is FETCH
    assign cpu_do_next = cpu_execute && (phase == INSTR_LEN - 1);
    assign cpu_do_halt = cpu_execute && (halt_after >= 0) && (retired == halt_after) && (phase == 1);

    always @(posedge clock) begin
        if (cpu_reset) begin
            phase   <= 0;
            retired <= 0;
        end else if (cpu_execute) begin
            phase <= (phase == INSTR_LEN - 1) ? 0 : phase + 1;
            if (cpu_do_next) retired <= retired + 1;
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] steps);
        int w = 0;
        @(negedge clock);
        while (!cmd_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        n_chk++;
        if (!cmd_ready) begin
            $display("FAIL cmd_accept op=%0d: cmd_ready=%0b, required 1", op, cmd_ready);
            n_err++;
        end else begin
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_steps = steps;
            @(posedge clock);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok, output int next_seen, output int exec_low);
        int c = 0;
        ok = 1'b0;
        next_seen = 0;
        exec_low = 0;
        while (c < budget) begin
            @(negedge clock);
            c++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (cpu_do_next) next_seen++;
            if (!cpu_execute) exec_low++;
        end
    endtask

    task automatic test_reset();
        bit ok; int ns, el;
        exp_q.push_back('{instr: 0, cycle: 0, halt: 0});
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if ({cpu_reset, cpu_execute, busy, cmd_ready, done, halted} !== 6'b101000) begin
            $display("FAIL reset_state: rst/exe/busy/rdy/done/halt=%b, required 101000",
                     {cpu_reset, cpu_execute, busy, cmd_ready, done, halted});
            n_err++;
        end
        @(negedge clock);
        n_chk++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
            $display("FAIL reset_hold2: cpu_reset=%b done=%b, required 1 0", cpu_reset, done);
            n_err++;
        end
        wait_done(1, ok, ns, el);
        n_chk++;
        if (!ok) begin
            $display("FAIL reset_done: no done pulse on third cycle, required one");
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv) begin
                $display("FAIL reset_counts: got %h, required %h", got, expv);
                n_err++;
            end
            if (cpu_reset !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                $display("FAIL reset_release: rst=%b rdy=%b busy=%b, required 0 1 0",
                         cpu_reset, cmd_ready, busy);
                n_err++;
            end
        end
    endtask

    task automatic test_step();
        bit ok; int ns, el;
        exp_q.push_back('{instr: 3, cycle: 15, halt: 0});
        send_cmd(OP_STEP, 16'd3);
        wait_done(40, ok, ns, el);
        n_chk++;
        if (!ok) begin
            $display("FAIL step3_done: timeout, required done pulse");
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv) begin
                $display("FAIL step3_counts: got %h, required %h", got, expv);
                n_err++;
            end
            n_chk++;
            if (ns !== 3 || el !== 0 || cpu_execute !== 1'b0 || phase !== 0) begin
                $display("FAIL step3_boundary: do_next=%0d exec_low=%0d exe=%b phase=%0d, required 3 0 0 0",
                         ns, el, cpu_execute, phase);
                n_err++;
            end
        end
        repeat (6) @(negedge clock);
        n_chk++;
        if (cpu_execute !== 1'b0 || retired !== 3 || busy !== 1'b0) begin
            $display("FAIL step3_parked: exe=%b retired=%0d busy=%b, required 0 3 0",
                     cpu_execute, retired, busy);
            n_err++;
        end
    endtask

    task automatic test_idle_commands();
        bit ok; int ns, el;
        exp_q.push_back('{instr: 3, cycle: 15, halt: 0});
        send_cmd(OP_STEP, 16'd0);
        wait_done(1, ok, ns, el);
        n_chk++;
        if (!ok || cpu_execute !== 1'b0) begin
            $display("FAIL step0_done: done=%b exe=%b, required 1 0 next cycle", ok, cpu_execute);
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv) begin
                $display("FAIL step0_counts: got %h, required %h", got, expv);
                n_err++;
            end
        end
        exp_q.push_back('{instr: 3, cycle: 15, halt: 0});
        send_cmd(OP_STOP, 16'd0);
        wait_done(1, ok, ns, el);
        n_chk++;
        if (!ok || cpu_execute !== 1'b0) begin
            $display("FAIL idle_stop_done: done=%b exe=%b, required 1 0 next cycle", ok, cpu_execute);
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv) begin
                $display("FAIL idle_stop_counts: got %h, required %h", got, expv);
                n_err++;
            end
        end
    endtask

    task automatic test_stop();
        bit ok; int ns, el, w, r0;
        r0 = retired;
        exp_q.push_back('{instr: 5, cycle: 25, halt: 0});
        send_cmd(OP_RUN, 16'd0);
        w = 0;
        // issue STOP while the second instruction is in its ALU phase
        while (!(phase == 2 && retired == r0 + 1) && w < 40) begin
            @(negedge clock);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        wait_done(20, ok, ns, el);
        n_chk++;
        if (!ok) begin
            $display("FAIL stop_done: timeout, required done pulse");
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv) begin
                $display("FAIL stop_counts: got %h, required %h", got, expv);
                n_err++;
            end
            n_chk++;
            if (el !== 0 || ns !== 1 || cpu_execute !== 1'b0 || busy !== 1'b0 || phase !== 0) begin
                $display("FAIL stop_boundary: exec_low=%0d do_next=%0d exe=%b busy=%b phase=%0d, required 0 1 0 0 0",
                         el, ns, cpu_execute, busy, phase);
                n_err++;
            end
        end
    endtask

    task automatic test_halt();
        bit ok; int ns, el;
        exp_q.push_back('{instr: 0, cycle: 0, halt: 0});
        send_cmd(OP_RESET, 16'd0);
        wait_done(5, ok, ns, el);
        n_chk++;
        if (!ok) begin
            $display("FAIL halt_prep_done: timeout after RESET_CPU");
            n_err++;
        end
        void'(exp_q.pop_front());
        halt_after = 5;
        exp_q.push_back('{instr: 5, cycle: 27, halt: 1});
        send_cmd(OP_RUN, 16'd0);
        wait_done(60, ok, ns, el);
        n_chk++;
        if (!ok) begin
            $display("FAIL halt_done: timeout, required done pulse");
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv || cpu_execute !== 1'b0) begin
                $display("FAIL halt_counts: got %h exe=%b, required %h exe=0", got, cpu_execute, expv);
                n_err++;
            end
        end
        exp_q.push_back('{instr: 5, cycle: 27, halt: 1});
        send_cmd(OP_RUN, 16'd0);
        wait_done(1, ok, ns, el);
        n_chk++;
        if (!ok) begin
            $display("FAIL halted_run_done: no done next cycle");
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv) begin
                $display("FAIL halted_run_counts: got %h, required %h", got, expv);
                n_err++;
            end
        end
        repeat (4) @(negedge clock);
        n_chk++;
        if (cpu_execute !== 1'b0 || halted !== 1'b1 || cmd_ready !== 1'b1) begin
            $display("FAIL halted_sticky: exe=%b halted=%b rdy=%b, required 0 1 1",
                     cpu_execute, halted, cmd_ready);
            n_err++;
        end
        halt_after = -1;
    endtask

    task automatic test_reset_cpu();
        bit ok; int ns, el;
        exp_q.push_back('{instr: 0, cycle: 0, halt: 0});
        send_cmd(OP_RESET, 16'd0);
        wait_done(5, ok, ns, el);
        n_chk++;
        if (!ok || halted !== 1'b0) begin
            $display("FAIL rcpu_from_halt: done=%b halted=%b, required 1 0", ok, halted);
            n_err++;
        end
        void'(exp_q.pop_front());
        send_cmd(OP_STEP, 16'd10);
        repeat (12) @(negedge clock);
        exp_q.push_back('{instr: 0, cycle: 0, halt: 0});
        send_cmd(OP_RESET, 16'd0);
        @(negedge clock);
        n_chk++;
        if (cpu_execute !== 1'b0 || cpu_reset !== 1'b1 || cmd_ready !== 1'b0) begin
            $display("FAIL rcpu_mid_step: exe=%b rst=%b rdy=%b, required 0 1 0",
                     cpu_execute, cpu_reset, cmd_ready);
            n_err++;
        end
        @(negedge clock);
        n_chk++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
            $display("FAIL rcpu_hold2: rst=%b done=%b, required 1 0", cpu_reset, done);
            n_err++;
        end
        wait_done(1, ok, ns, el);
        n_chk++;
        if (!ok) begin
            $display("FAIL rcpu_done: no done after two reset cycles");
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv || cpu_reset !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL rcpu_counts: got %h rst=%b busy=%b, required %h 0 0",
                         got, cpu_reset, busy, expv);
                n_err++;
            end
        end
        repeat (8) @(negedge clock);
        n_chk++;
        if (cpu_execute !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rcpu_steps_discarded: exe=%b busy=%b, required 0 0", cpu_execute, busy);
            n_err++;
        end
        send_cmd(OP_RUN, 16'd0);
        repeat (7) @(negedge clock);
        exp_q.push_back('{instr: 0, cycle: 0, halt: 0});
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (cpu_execute !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            $display("FAIL reset_mid_run: exe=%b rst=%b busy=%b rdy=%b, required 0 1 1 0",
                     cpu_execute, cpu_reset, busy, cmd_ready);
            n_err++;
        end
        wait_done(3, ok, ns, el);
        n_chk++;
        if (!ok) begin
            $display("FAIL reset_mid_run_done: no done pulse");
            n_err++;
            void'(exp_q.pop_front());
        end else begin
            got = '{instr: instr_count, cycle: cycle_count, halt: halted};
            expv = exp_q.pop_front();
            n_chk++;
            if (got !== expv || cpu_execute !== 1'b0) begin
                $display("FAIL reset_mid_run_counts: got %h exe=%b, required %h 0", got, cpu_execute, expv);
                n_err++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_idle_commands();
        test_stop();
        test_halt();
        test_reset_cpu();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
